byte_write_dp_ram: RTL and testbench
====================================

BYTE_WRITE_DP_RAM -- requirements
Module: byte_write_dp_ram

Interface
REQ-001 SHALL have parameter COLS, 4, byte-enable columns per word.
REQ-002 SHALL have parameter COL_BITS, 8, bits per column.
REQ-003 SHALL have parameter ADDR_BITS, 5, address width; depth = 2**ADDR_BITS.
REQ-004 SHALL have parameter RD_MODE, READ_FIRST, port-A and port-B collision policy (READ_FIRST | WRITE_FIRST).
REQ-005 SHALL have parameter OUT_REG, 0, 1 adds an output register stage to both read ports.
REQ-006 SHALL derive localparam DATA_BITS = COLS*COL_BITS.
REQ-007 SHALL have port clk  in  1  sole clock, all logic on posedge.
REQ-008 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port a_en  in  1  port-A access enable.
REQ-010 SHALL have port a_we  in  COLS  port-A per-column write enable.
REQ-011 SHALL have port a_addr  in  ADDR_BITS  port-A address.
REQ-012 SHALL have port a_data_i  in  DATA_BITS  port-A write data.
REQ-013 SHALL have port a_data_o  out  DATA_BITS  port-A read data.
REQ-014 SHALL have port a_valid_o  out  1  a_data_o updated this cycle.
REQ-015 SHALL have port b_en  in  1  port-B read enable.
REQ-016 SHALL have port b_addr  in  ADDR_BITS  port-B read address.
REQ-017 SHALL have port b_data_o  out  DATA_BITS  port-B read data.
REQ-018 SHALL have port b_valid_o  out  1  b_data_o updated this cycle.
REQ-019 SHALL have port busy_o  out  1  initialisation sweep in progress; requests ignored.

Function
REQ-020 SHALL implement FSM {CLEAR, READY}; CLEAR writes all-zero to entry clr_cnt each cycle, clr_cnt incrementing from 0.
REQ-021 SHALL transition CLEAR->READY in the cycle after entry 2**ADDR_BITS-1 is written; sweep length exactly 2**ADDR_BITS cycles after rst deasserts.
REQ-022 SHALL hold busy_o=1 in CLEAR and 0 in READY; a_en and b_en SHALL be ignored (no write, no valid) while busy_o=1.
REQ-023 SHALL, in READY with a_en=1, write each column i with a_we[i]=1 and leave other columns unchanged.
REQ-024 SHALL return read data 1 cycle after the enable (OUT_REG=0) or 2 cycles after (OUT_REG=1); a_valid_o/b_valid_o SHALL pulse with the same latency.
REQ-025 SHALL hold a_data_o/b_data_o unchanged when no valid pulse occurs.
REQ-026 SHALL, on port-A read-during-write, return old word (READ_FIRST) or old word with written columns replaced by a_data_i (WRITE_FIRST).
REQ-027 SHALL, when b_en and a write hit the same address in one cycle, apply the RD_MODE policy of REQ-026 to port B.
REQ-028 SHALL allow simultaneous A and B accesses to different addresses with no interaction.
REQ-029 SHALL pipeline valid alongside data so back-to-back enables give back-to-back valids at full throughput.

Reset
REQ-030 SHALL, while rst=1: state=CLEAR, clr_cnt=0, busy_o=1, a_valid_o=0, b_valid_o=0, a_data_o=0, b_data_o=0, output-stage registers 0.
REQ-031 SHALL restart the sweep from entry 0 when rst asserts mid-sweep or mid-operation; in-flight reads SHALL be discarded (no valid).
REQ-032 SHALL not clear the memory array combinationally; contents are zeroed only by the sweep.

Structure
REQ-033 SHALL place rd_mode_e (READ_FIRST, WRITE_FIRST) and clr_state_e (CLEAR, READY) in shared package ram_pkg.
REQ-034 SHALL place a column-merge function (old word, new word, we mask -> merged word) in ram_pkg; no sub-module.
REQ-035 SHALL keep the array as a single inferable memory with one write port and two read ports.

Verification
REQ-036 SHALL check reset: rst 1 cycle, ADDR_BITS=5 -> busy_o high exactly 32 cycles after release, then every address reads 0.
REQ-037 SHALL check byte write: write 0xAABBCCDD at 3 with a_we=1111, then 0x11223344 with a_we=0101 -> port B reads 0xAA22CC44.
REQ-038 SHALL check collision: entry 7=0x0, a_we=1111 data 0xDEADBEEF, b_en addr 7 same cycle -> b_data_o=0x0 (READ_FIRST), 0xDEADBEEF (WRITE_FIRST).
REQ-039 SHALL check latency: OUT_REG=1, 4 back-to-back B reads -> 4 consecutive valids starting 2 cycles after first enable.
REQ-040 SHALL check busy gating: a_en writes 0xFF.. at addr 0 during sweep -> addr 0 reads 0, no valid during busy.
REQ-041 SHALL check mid-sweep reset: rst at sweep cycle 10 -> busy_o stays high 32 further cycles after release.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and the column-merge helper for the byte-write dual-port RAM.
// Not a stage itself: no latency or backpressure of its own.
package ram_pkg;

    typedef enum logic {READ_FIRST, WRITE_FIRST} rd_mode_e;
    typedef enum logic {CLEAR, READY} clr_state_e;

    localparam int MAX_COLS = 32;
    localparam int MAX_BITS = 256;

    // Replace the columns of old_word selected by we with the matching columns of new_word.
    function automatic logic [MAX_BITS-1:0] col_merge(
        input logic [MAX_BITS-1:0] old_word,
        input logic [MAX_BITS-1:0] new_word,
        input logic [MAX_COLS-1:0] we,
        input int                  col_bits
    );
        logic [MAX_BITS-1:0] merged;
        merged = old_word;
        for (int c = 0; c < MAX_COLS; c++) begin
            for (int k = 0; k < col_bits; k++) begin
                if (we[c] && (c * col_bits + k) < MAX_BITS) begin
                    merged[c * col_bits + k] = new_word[c * col_bits + k];
                end
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/byte_write_dp_ram.sv
// Dual-port RAM: port A read/write with per-column enables, port B read-only; zeroed by a sweep after reset.
// Read latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); no backpressure, requests are dropped while busy_o is high.
module byte_write_dp_ram
    import ram_pkg::*;
#(
    parameter int       COLS      = 4,
    parameter int       COL_BITS  = 8,
    parameter int       ADDR_BITS = 5,
    parameter rd_mode_e RD_MODE   = READ_FIRST,
    parameter int       OUT_REG   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_en,
    input  logic [COLS-1:0]               a_we,
    input  logic [ADDR_BITS-1:0]          a_addr,
    input  logic [COLS*COL_BITS-1:0]      a_data_i,
    output logic [COLS*COL_BITS-1:0]      a_data_o,
    output logic                          a_valid_o,
    input  logic                          b_en,
    input  logic [ADDR_BITS-1:0]          b_addr,
    output logic [COLS*COL_BITS-1:0]      b_data_o,
    output logic                          b_valid_o,
    output logic                          busy_o
);

    localparam int DATA_BITS = COLS * COL_BITS;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    function automatic logic [DATA_BITS-1:0] merge_word(
        input logic [DATA_BITS-1:0] old_word,
        input logic [DATA_BITS-1:0] new_word,
        input logic [COLS-1:0]      we
    );
        logic [MAX_BITS-1:0] m;
        m = col_merge(MAX_BITS'(old_word), MAX_BITS'(new_word), MAX_COLS'(we), COL_BITS);
        return m[DATA_BITS-1:0];
    endfunction

    logic [DATA_BITS-1:0] mem [DEPTH];

    clr_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;

    logic                 wr_en;
    logic [COLS-1:0]      wr_we;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_dat;
    logic                 a_req, b_req;
    logic [DATA_BITS-1:0] a_mem_word, b_mem_word;

    logic                 a_rd_vld_q, a_rd_vld_d, b_rd_vld_q, b_rd_vld_d;
    logic [DATA_BITS-1:0] a_rd_dat_q, a_rd_dat_d, b_rd_dat_q, b_rd_dat_d;
    logic                 a_out_vld_q, a_out_vld_d, b_out_vld_q, b_out_vld_d;
    logic [DATA_BITS-1:0] a_out_dat_q, a_out_dat_d, b_out_dat_q, b_out_dat_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_en     = 1'b0;
        wr_we     = a_we;
        wr_addr   = a_addr;
        wr_dat    = a_data_i;
        a_req     = 1'b0;
        b_req     = 1'b0;
        unique case (state_q)
            CLEAR: begin
                wr_en     = 1'b1;
                wr_we     = '1;
                wr_addr   = clr_cnt_q;
                wr_dat    = '0;
                clr_cnt_d = clr_cnt_q + ADDR_BITS'(1);
                if (&clr_cnt_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                a_req = a_en;
                b_req = b_en;
                wr_en = a_en && (|a_we);
            end
        endcase
        if (rst) begin
            wr_en = 1'b0;
            a_req = 1'b0;
            b_req = 1'b0;
        end
    end

    // Array reads see the pre-write word; WRITE_FIRST patches in the columns being written.
    always_comb begin
        a_mem_word = mem[a_addr];
        b_mem_word = mem[b_addr];
        a_rd_vld_d = a_req;
        b_rd_vld_d = b_req;
        a_rd_dat_d = a_rd_dat_q;
        b_rd_dat_d = b_rd_dat_q;
        if (a_req) begin
            a_rd_dat_d = (RD_MODE == WRITE_FIRST && wr_en) ?
                         merge_word(a_mem_word, a_data_i, a_we) : a_mem_word;
        end
        if (b_req) begin
            b_rd_dat_d = (RD_MODE == WRITE_FIRST && wr_en && b_addr == a_addr) ?
                         merge_word(b_mem_word, a_data_i, a_we) : b_mem_word;
        end
    end

    always_comb begin
        a_out_vld_d = a_rd_vld_q;
        b_out_vld_d = b_rd_vld_q;
        a_out_dat_d = a_rd_vld_q ? a_rd_dat_q : a_out_dat_q;
        b_out_dat_d = b_rd_vld_q ? b_rd_dat_q : b_out_dat_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < COLS; c++) begin
                if (wr_we[c]) begin
                    mem[wr_addr][c*COL_BITS +: COL_BITS] <= wr_dat[c*COL_BITS +: COL_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            a_rd_vld_q  <= 1'b0;
            b_rd_vld_q  <= 1'b0;
            a_rd_dat_q  <= '0;
            b_rd_dat_q  <= '0;
            a_out_vld_q <= 1'b0;
            b_out_vld_q <= 1'b0;
            a_out_dat_q <= '0;
            b_out_dat_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            a_rd_vld_q  <= a_rd_vld_d;
            b_rd_vld_q  <= b_rd_vld_d;
            a_rd_dat_q  <= a_rd_dat_d;
            b_rd_dat_q  <= b_rd_dat_d;
            a_out_vld_q <= a_out_vld_d;
            b_out_vld_q <= b_out_vld_d;
            a_out_dat_q <= a_out_dat_d;
            b_out_dat_q <= b_out_dat_d;
        end
    end

    assign busy_o    = (state_q == CLEAR);
    assign a_valid_o = (OUT_REG != 0) ? a_out_vld_q : a_rd_vld_q;
    assign b_valid_o = (OUT_REG != 0) ? b_out_vld_q : b_rd_vld_q;
    assign a_data_o  = (OUT_REG != 0) ? a_out_dat_q : a_rd_dat_q;
    assign b_data_o  = (OUT_REG != 0) ? b_out_dat_q : b_rd_dat_q;

endmodule

// File: tb/tb_byte_write_dp_ram.sv
// Directed bench driving two instances in lockstep: READ_FIRST/OUT_REG=0 (r_*) and WRITE_FIRST/OUT_REG=1 (w_*).
module tb_byte_write_dp_ram;
    import ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0;
    logic [3:0]  a_we = '0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data_i = '0;
    logic        b_en = 1'b0;
    logic [4:0]  b_addr = '0;

    logic [31:0] r_a_data, r_b_data, w_a_data, w_b_data;
    logic        r_a_valid, r_b_valid, w_a_valid, w_b_valid, r_busy, w_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    byte_write_dp_ram #(.COLS(4), .COL_BITS(8), .ADDR_BITS(5), .RD_MODE(READ_FIRST), .OUT_REG(0)) u_rf (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_data_i(a_data_i),
        .a_data_o(r_a_data), .a_valid_o(r_a_valid), .b_en(b_en), .b_addr(b_addr),
        .b_data_o(r_b_data), .b_valid_o(r_b_valid), .busy_o(r_busy));

    byte_write_dp_ram #(.COLS(4), .COL_BITS(8), .ADDR_BITS(5), .RD_MODE(WRITE_FIRST), .OUT_REG(1)) u_wf (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_data_i(a_data_i),
        .a_data_o(w_a_data), .a_valid_o(w_a_valid), .b_en(b_en), .b_addr(b_addr),
        .b_data_o(w_b_data), .b_valid_o(w_b_valid), .busy_o(w_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_b(input logic [4:0] addr, output logic rv, output logic [31:0] rd,
                          output logic wv, output logic [31:0] wd);
        b_en = 1'b1; b_addr = addr;
        tick();
        b_en = 1'b0;
        rv = r_b_valid; rd = r_b_data;
        tick();
        wv = w_b_valid; wd = w_b_data;
    endtask

    task automatic access_a(input logic [4:0] addr, input logic [3:0] we, input logic [31:0] dat,
                            output logic rv, output logic [31:0] rd,
                            output logic wv, output logic [31:0] wd);
        a_en = 1'b1; a_addr = addr; a_we = we; a_data_i = dat;
        tick();
        a_en = 1'b0; a_we = '0;
        rv = r_a_valid; rd = r_a_data;
        tick();
        wv = w_a_valid; wd = w_a_data;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (r_busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        logic rv, wv;
        logic [31:0] rd, wd;
        rst = 1'b1;
        tick();
        tests++;
        if ({r_busy, w_busy, r_a_valid, r_b_valid, w_a_valid, w_b_valid} !== 6'b110000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 110000",
                     {r_busy, w_busy, r_a_valid, r_b_valid, w_a_valid, w_b_valid});
        end
        tests++;
        if ({r_a_data, r_b_data, w_a_data, w_b_data} !== 128'd0) begin
            fails++;
            $display("FAIL reset_data: got %h %h %h %h expected 0", r_a_data, r_b_data, w_a_data, w_b_data);
        end
        rst = 1'b0;
        count_busy(n);
        tests++;
        if (n !== 32 || w_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_sweep_len: got %0d cycles (w_busy=%b) expected 32 (0)", n, w_busy);
        end
        for (int a = 0; a < 32; a++) begin
            read_b(5'(a), rv, rd, wv, wd);
            tests++;
            if (rv !== 1'b1 || rd !== 32'd0 || wv !== 1'b1 || wd !== 32'd0) begin
                fails++;
                $display("FAIL reset_clear[%0d]: got r=%b/%h w=%b/%h expected 1/0 1/0", a, rv, rd, wv, wd);
            end
        end
    endtask

    task automatic test_busy_gating();
        int n;
        logic seen;
        logic rv, wv;
        logic [31:0] rd, wd;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_en = 1'b1; a_we = 4'hF; a_addr = 5'd0; a_data_i = 32'hFFFF_FFFF;
        b_en = 1'b1; b_addr = 5'd0;
        seen = 1'b0;
        n = 0;
        while (r_busy && n < 100) begin
            if (r_a_valid || r_b_valid || w_a_valid || w_b_valid) seen = 1'b1;
            n++;
            tick();
        end
        a_en = 1'b0; a_we = '0; b_en = 1'b0;
        tests++;
        if (seen !== 1'b0 || n !== 32) begin
            fails++;
            $display("FAIL busy_gating_valid: got valid_seen=%b cycles=%0d expected 0 32", seen, n);
        end
        read_b(5'd0, rv, rd, wv, wd);
        tests++;
        if (rv !== 1'b1 || rd !== 32'd0 || wv !== 1'b1 || wd !== 32'd0) begin
            fails++;
            $display("FAIL busy_gating_addr0: got r=%b/%h w=%b/%h expected 1/0 1/0", rv, rd, wv, wd);
        end
    endtask

    task automatic test_byte_write();
        logic rv, wv;
        logic [31:0] rd, wd;
        access_a(5'd3, 4'b1111, 32'hAABB_CCDD, rv, rd, wv, wd);
        access_a(5'd3, 4'b0101, 32'h1122_3344, rv, rd, wv, wd);
        tests++;
        if (rv !== 1'b1 || rd !== 32'hAABB_CCDD || wv !== 1'b1 || wd !== 32'hAA22_CC44) begin
            fails++;
            $display("FAIL a_rdw: got r=%b/%h w=%b/%h expected 1/aabbccdd 1/aa22cc44", rv, rd, wv, wd);
        end
        read_b(5'd3, rv, rd, wv, wd);
        tests++;
        if (rv !== 1'b1 || rd !== 32'hAA22_CC44 || wv !== 1'b1 || wd !== 32'hAA22_CC44) begin
            fails++;
            $display("FAIL byte_write_b: got r=%b/%h w=%b/%h expected aa22cc44", rv, rd, wv, wd);
        end
        access_a(5'd3, 4'b0000, 32'h0, rv, rd, wv, wd);
        tests++;
        if (rv !== 1'b1 || rd !== 32'hAA22_CC44 || wv !== 1'b1 || wd !== 32'hAA22_CC44) begin
            fails++;
            $display("FAIL byte_write_a: got r=%b/%h w=%b/%h expected aa22cc44", rv, rd, wv, wd);
        end
    endtask

    task automatic test_collision();
        logic rv, wv;
        logic [31:0] rd, wd;
        a_en = 1'b1; a_we = 4'hF; a_addr = 5'd7; a_data_i = 32'hDEAD_BEEF;
        b_en = 1'b1; b_addr = 5'd7;
        tick();
        a_en = 1'b0; a_we = '0; b_en = 1'b0;
        rv = r_b_valid; rd = r_b_data;
        tick();
        wv = w_b_valid; wd = w_b_data;
        tests++;
        if (rv !== 1'b1 || rd !== 32'd0 || wv !== 1'b1 || wd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL collision: got r=%b/%h w=%b/%h expected 1/0 1/deadbeef", rv, rd, wv, wd);
        end
        read_b(5'd7, rv, rd, wv, wd);
        tests++;
        if (rd !== 32'hDEAD_BEEF || wd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL collision_after: got %h %h expected deadbeef", rd, wd);
        end
    endtask

    task automatic test_parallel();
        logic rv, wv;
        logic [31:0] rd, wd;
        a_en = 1'b1; a_we = 4'hF; a_addr = 5'd9; a_data_i = 32'h1234_5678;
        b_en = 1'b1; b_addr = 5'd3;
        tick();
        a_en = 1'b0; a_we = '0; b_en = 1'b0;
        rv = r_b_valid; rd = r_b_data;
        tick();
        wv = w_b_valid; wd = w_b_data;
        tests++;
        if (rv !== 1'b1 || rd !== 32'hAA22_CC44 || wv !== 1'b1 || wd !== 32'hAA22_CC44) begin
            fails++;
            $display("FAIL parallel_b: got r=%b/%h w=%b/%h expected aa22cc44", rv, rd, wv, wd);
        end
        read_b(5'd9, rv, rd, wv, wd);
        tests++;
        if (rd !== 32'h1234_5678 || wd !== 32'h1234_5678) begin
            fails++;
            $display("FAIL parallel_a_write: got %h %h expected 12345678", rd, wd);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addrs [4];
        logic [31:0] exp   [4];
        addrs = '{5'd0, 5'd3, 5'd7, 5'd9};
        exp   = '{32'h0, 32'hAA22_CC44, 32'hDEAD_BEEF, 32'h1234_5678};
        b_en = 1'b1; b_addr = addrs[0];
        for (int s = 0; s < 6; s++) begin
            tick();
            if (s < 3) b_addr = addrs[s+1];
            else b_en = 1'b0;
            tests++;
            if (s < 4) begin
                if (r_b_valid !== 1'b1 || r_b_data !== exp[s]) begin
                    fails++;
                    $display("FAIL b2b_r[%0d]: got %b/%h expected 1/%h", s, r_b_valid, r_b_data, exp[s]);
                end
            end else if (r_b_valid !== 1'b0) begin
                fails++;
                $display("FAIL b2b_r[%0d]: got valid %b expected 0", s, r_b_valid);
            end
            tests++;
            if (s >= 1 && s <= 4) begin
                if (w_b_valid !== 1'b1 || w_b_data !== exp[s-1]) begin
                    fails++;
                    $display("FAIL b2b_w[%0d]: got %b/%h expected 1/%h", s, w_b_valid, w_b_data, exp[s-1]);
                end
            end else if (w_b_valid !== 1'b0) begin
                fails++;
                $display("FAIL b2b_w[%0d]: got valid %b expected 0", s, w_b_valid);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (r_b_valid !== 1'b0 || w_b_valid !== 1'b0 ||
                r_b_data !== 32'h1234_5678 || w_b_data !== 32'h1234_5678) begin
                fails++;
                $display("FAIL hold[%0d]: got r=%b/%h w=%b/%h expected 0/12345678", i,
                         r_b_valid, r_b_data, w_b_valid, w_b_data);
            end
        end
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        logic rv, wv;
        logic [31:0] rd, wd;
        b_en = 1'b1; b_addr = 5'd9;
        tick();
        b_en = 1'b0;
        rst = 1'b1;
        tick();
        tests++;
        if (w_b_valid !== 1'b0 || w_b_data !== 32'd0 || r_b_data !== 32'd0 || r_busy !== 1'b1) begin
            fails++;
            $display("FAIL inflight_discard: got w=%b/%h r=%h busy=%b expected 0/0 0 1",
                     w_b_valid, w_b_data, r_b_data, r_busy);
        end
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n);
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL mid_sweep_len: got %0d cycles expected 32", n);
        end
        read_b(5'd9, rv, rd, wv, wd);
        tests++;
        if (rd !== 32'd0 || wd !== 32'd0) begin
            fails++;
            $display("FAIL mid_sweep_cleared: got %h %h expected 0", rd, wd);
        end
    endtask

    initial begin
        test_reset();
        test_busy_gating();
        test_byte_write();
        test_collision();
        test_parallel();
        test_back_to_back();
        test_hold();
        test_mid_sweep_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
